// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, FSM states,
// and the bit positions of the instruction fields.
package cpu_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 2;
  localparam int RD_HI  = 1;
  localparam int RD_LO  = 0;
  localparam int OFF_HI = 5;
  localparam int OFF_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PCUPD  = 3'd5
  } state_t;

  // Extract the opcode field from an instruction byte.
  function automatic logic [1:0] instr_op(input logic [7:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on data memory; EXPIRED marks the LIMIT-th
// cycle of a wait (count starts at 0 on the first enabled cycle).
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);

  logic [7:0] count_reg;

  // Saturating wait counter; cleared whenever the FSM is outside MEM.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      count_reg <= 8'd0;
    end else if (EN && !EXPIRED) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign EXPIRED = (count_reg == 8'(LIMIT - 1));

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multicycle control FSM: accepts one instruction per handshake, sequences
// the register file and data memory, strobes PC updates, counts retirements.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INSTR_VALID,
  input  logic [7:0]       INSTR,
  output logic             INSTR_READY,
  input  logic             MEM_ACK,
  output logic [1:0]       REG_SOURCE,
  output logic [1:0]       REG_TWO,
  output logic [1:0]       REG_DEST,
  output logic             REGDST,
  output logic             REGWRITE,
  output logic             MEMTOREG,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic             PC_WRITE,
  output logic             PC_SRC,
  output logic [5:0]       JUMP_OFFSET,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  state_t           state_reg, state_next;
  logic [7:0]       instr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  logic [1:0]       op;
  logic             mem_expired;
  logic             timeout_abort;

  assign op            = instr_op(instr_reg);
  assign timeout_abort = (state_reg == S_MEM) && !MEM_ACK && mem_expired;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .CLR     (state_reg != S_MEM),
    .EN      (state_reg == S_MEM),
    .EXPIRED (mem_expired)
  );

  // State, latched instruction, retire counter and timeout error pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      instr_reg <= 8'd0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && INSTR_VALID) begin
        instr_reg <= INSTR;
      end
      if (state_reg == S_PCUPD) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      err_reg <= timeout_abort;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next  = state_reg;
    INSTR_READY = 1'b0;
    REGDST      = 1'b0;
    REGWRITE    = 1'b0;
    MEMTOREG    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    PC_WRITE    = 1'b0;
    PC_SRC      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = (op == OP_J) ? S_PCUPD : S_EXEC;
      end
      S_EXEC: begin
        state_next = (op == OP_ADD) ? S_WB : S_MEM;
      end
      S_MEM: begin
        MEM_READ  = (op == OP_LW);
        MEM_WRITE = (op == OP_SW);
        if (MEM_ACK) begin
          state_next = (op == OP_LW) ? S_WB : S_PCUPD;
        end else if (mem_expired) begin
          state_next = S_IDLE;
        end
      end
      S_WB: begin
        REGWRITE   = 1'b1;
        REGDST     = (op == OP_ADD);
        MEMTOREG   = (op == OP_LW);
        state_next = S_PCUPD;
      end
      S_PCUPD: begin
        PC_WRITE   = 1'b1;
        PC_SRC     = (op == OP_J);
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Addresses come straight from the latched instruction so they stay
  // stable from DECODE until the next accept.
  assign REG_SOURCE  = instr_reg[RS_HI:RS_LO];
  assign REG_TWO     = instr_reg[RT_HI:RT_LO];
  assign REG_DEST    = instr_reg[RD_HI:RD_LO];
  assign JUMP_OFFSET = instr_reg[OFF_HI:OFF_LO];
  assign ERR         = err_reg;
  assign INSTR_COUNT = count_reg;

endmodule
